// File: rtl/tc_pkg.sv
// Shared types, sizes and index/tag helpers for the set-associative indirect-branch target cache.
package tc_pkg;

  localparam int PC_W     = 32;
  localparam int BHR_W    = 4;
  localparam int PC_IDX_W = 4;
  localparam int TAG_W    = 10;
  localparam int WAYS     = 2;
  localparam int CONF_W   = 2;

  localparam int IDX_W = PC_IDX_W + BHR_W;
  localparam int SETS  = 1 << IDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [CONF_W-1:0] CONF_MAX = {CONF_W{1'b1}};

  typedef logic [PC_W-1:0]   pc_t;
  typedef logic [BHR_W-1:0]  bhr_t;
  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [CONF_W-1:0] conf_t;
  typedef logic [WAY_W-1:0]  way_t;

  typedef struct packed {
    logic  valid;
    tag_t  tag;
    pc_t   target;
    conf_t conf;
  } entry_t;

  function automatic idx_t set_idx(input pc_t pc, input bhr_t bhr);
    return {pc[PC_IDX_W-1:0], bhr};
  endfunction

  function automatic tag_t pc_tag(input pc_t pc);
    return pc[PC_IDX_W +: TAG_W];
  endfunction

endpackage

// File: rtl/tc_alloc_sel.sv
// Chooses the way to fill on an update miss: lowest invalid way, else the set's round-robin victim.
module tc_alloc_sel
  import tc_pkg::*;
(
  input  logic [WAYS-1:0] i_valid,
  input  way_t            i_victim,
  output way_t            o_alloc_way,
  output logic            o_replaced
);

  // Scanning downward leaves the lowest-numbered invalid way as the final pick.
  always_comb begin
    o_alloc_way = i_victim;
    o_replaced  = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!i_valid[w]) begin
        o_alloc_way = way_t'(w);
        o_replaced  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/assoc_target_cache.sv
// Tagged set-associative indirect-branch target cache with a registered lookup and a commit-side update port.
module assoc_target_cache
  import tc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              lookup_en,
  input  logic [PC_W-1:0]   lookup_pc,
  input  logic [BHR_W-1:0]  lookup_bhr,
  output logic              pred_valid,
  output logic              pred_hit,
  output logic [PC_W-1:0]   pred_target,
  output logic [CONF_W-1:0] pred_conf,
  input  logic              update_en,
  input  logic [PC_W-1:0]   update_pc,
  input  logic [BHR_W-1:0]  update_bhr,
  input  logic [PC_W-1:0]   update_target,
  input  logic              flush
);

  logic [WAYS-1:0] r_valid  [SETS];
  way_t            r_victim [SETS];
  tag_t            r_tag    [SETS][WAYS];
  pc_t             r_target [SETS][WAYS];
  conf_t           r_conf   [SETS][WAYS];

  logic            r_pred_valid;
  logic            r_pred_hit;
  pc_t             r_pred_target;
  conf_t           r_pred_conf;

  idx_t            w_lk_idx;
  tag_t            w_lk_tag;
  entry_t          w_lk_way [WAYS];
  logic            w_lk_hit;
  pc_t             w_lk_target;
  conf_t           w_lk_conf;

  idx_t            w_up_idx;
  tag_t            w_up_tag;
  logic            w_up_hit;
  way_t            w_up_hit_way;
  way_t            w_alloc_way;
  logic            w_replaced;
  way_t            w_wr_way;
  pc_t             w_new_target;
  conf_t           w_new_conf;
  logic            w_do_upd;
  logic            w_unused_pc_bits;

  assign w_lk_idx = set_idx(lookup_pc, lookup_bhr);
  assign w_lk_tag = pc_tag(lookup_pc);
  assign w_up_idx = set_idx(update_pc, update_bhr);
  assign w_up_tag = pc_tag(update_pc);
  assign w_unused_pc_bits = ^{lookup_pc[PC_W-1:PC_IDX_W+TAG_W], update_pc[PC_W-1:PC_IDX_W+TAG_W]};

  // Lookup read and tag compare; a miss yields zero target and confidence.
  always_comb begin
    w_lk_hit    = 1'b0;
    w_lk_target = '0;
    w_lk_conf   = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_lk_way[w] = '{valid:  r_valid[w_lk_idx][w],
                      tag:    r_tag[w_lk_idx][w],
                      target: r_target[w_lk_idx][w],
                      conf:   r_conf[w_lk_idx][w]};
      if (w_lk_way[w].valid && (w_lk_way[w].tag == w_lk_tag)) begin
        w_lk_hit    = 1'b1;
        w_lk_target = w_lk_way[w].target;
        w_lk_conf   = w_lk_way[w].conf;
      end
    end
  end

  // Update-side tag compare.
  always_comb begin
    w_up_hit     = 1'b0;
    w_up_hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_up_idx][w] && (r_tag[w_up_idx][w] == w_up_tag)) begin
        w_up_hit     = 1'b1;
        w_up_hit_way = way_t'(w);
      end
    end
  end

  tc_alloc_sel u_alloc_sel (
    .i_valid     (r_valid[w_up_idx]),
    .i_victim    (r_victim[w_up_idx]),
    .o_alloc_way (w_alloc_way),
    .o_replaced  (w_replaced)
  );

  assign w_wr_way = w_up_hit ? w_up_hit_way : w_alloc_way;
  assign w_do_upd = update_en & ~flush & ~reset;

  // Hysteresis: a wrong target only replaces the stored one once confidence has drained to zero.
  always_comb begin
    w_new_target = update_target;
    w_new_conf   = '0;
    if (w_up_hit) begin
      w_new_target = r_target[w_up_idx][w_up_hit_way];
      if (r_target[w_up_idx][w_up_hit_way] == update_target) begin
        w_new_conf = (r_conf[w_up_idx][w_up_hit_way] == CONF_MAX) ? CONF_MAX
                   : r_conf[w_up_idx][w_up_hit_way] + conf_t'(1);
      end else if (r_conf[w_up_idx][w_up_hit_way] == conf_t'(0)) begin
        w_new_target = update_target;
        w_new_conf   = '0;
      end else begin
        w_new_conf = r_conf[w_up_idx][w_up_hit_way] - conf_t'(1);
      end
    end
  end

  // Valid bits and victim pointers; the victim only moves when a valid way is evicted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s]  <= '0;
        r_victim[s] <= '0;
      end
    end else if (flush) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
      end
    end else if (update_en && !w_up_hit) begin
      r_valid[w_up_idx][w_alloc_way] <= 1'b1;
      if (w_replaced) begin
        r_victim[w_up_idx] <= r_victim[w_up_idx] + way_t'(1);
      end
    end
  end

  // Payload arrays stay unreset; valid bits alone decide whether they are visible.
  always_ff @(posedge clk) begin
    if (w_do_upd) begin
      r_tag[w_up_idx][w_wr_way]    <= w_up_tag;
      r_target[w_up_idx][w_wr_way] <= w_new_target;
      r_conf[w_up_idx][w_wr_way]   <= w_new_conf;
    end
  end

  // Prediction registers; result fields hold when no lookup is issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pred_valid  <= 1'b0;
      r_pred_hit    <= 1'b0;
      r_pred_target <= '0;
      r_pred_conf   <= '0;
    end else if (lookup_en) begin
      r_pred_valid  <= 1'b1;
      r_pred_hit    <= w_lk_hit;
      r_pred_target <= w_lk_target;
      r_pred_conf   <= w_lk_conf;
    end else begin
      r_pred_valid  <= 1'b0;
    end
  end

  assign pred_valid  = r_pred_valid;
  assign pred_hit    = r_pred_hit;
  assign pred_target = r_pred_target;
  assign pred_conf   = r_pred_conf;

endmodule

// File: tb/tb_assoc_target_cache.sv
// Directed plus randomized bench for assoc_target_cache against a behavioural reference model.
module tb_assoc_target_cache;

  localparam int NSETS    = 256;
  localparam int NWAYS    = 2;
  localparam int CONF_TOP = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        lookup_en;
  logic [31:0] lookup_pc;
  logic [3:0]  lookup_bhr;
  logic        pred_valid;
  logic        pred_hit;
  logic [31:0] pred_target;
  logic [1:0]  pred_conf;
  logic        update_en;
  logic [31:0] update_pc;
  logic [3:0]  update_bhr;
  logic [31:0] update_target;
  logic        flush;

  int n_checks = 0;
  int n_fail   = 0;

  bit          m_valid [NSETS][NWAYS];
  logic [9:0]  m_tag   [NSETS][NWAYS];
  logic [31:0] m_tgt   [NSETS][NWAYS];
  int          m_conf  [NSETS][NWAYS];
  int          m_vict  [NSETS];

  logic        e_valid;
  logic        e_hit;
  logic [31:0] e_tgt;
  logic [1:0]  e_conf;

  assoc_target_cache dut (
    .clk           (clk),
    .reset         (reset),
    .lookup_en     (lookup_en),
    .lookup_pc     (lookup_pc),
    .lookup_bhr    (lookup_bhr),
    .pred_valid    (pred_valid),
    .pred_hit      (pred_hit),
    .pred_target   (pred_target),
    .pred_conf     (pred_conf),
    .update_en     (update_en),
    .update_pc     (update_pc),
    .update_bhr    (update_bhr),
    .update_target (update_target),
    .flush         (flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc, input logic [3:0] bhr);
    return int'(pc[3:0]) * 16 + int'(bhr);
  endfunction

  function automatic logic [9:0] tag_of(input logic [31:0] pc);
    return pc[13:4];
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NSETS; s++) begin
      m_vict[s] = 0;
      for (int w = 0; w < NWAYS; w++) m_valid[s][w] = 1'b0;
    end
  endtask

  task automatic model_flush();
    for (int s = 0; s < NSETS; s++)
      for (int w = 0; w < NWAYS; w++) m_valid[s][w] = 1'b0;
  endtask

  task automatic model_lookup(input logic [31:0] pc, input logic [3:0] bhr,
                              output logic h, output logic [31:0] t, output logic [1:0] c);
    int s;
    s = idx_of(pc, bhr);
    h = 1'b0; t = 32'h0; c = 2'd0;
    for (int w = 0; w < NWAYS; w++) begin
      if (m_valid[s][w] && m_tag[s][w] == tag_of(pc)) begin
        h = 1'b1; t = m_tgt[s][w]; c = 2'(m_conf[s][w]);
      end
    end
  endtask

  task automatic model_update(input logic [31:0] pc, input logic [3:0] bhr, input logic [31:0] tgt);
    int s, hw, aw;
    s = idx_of(pc, bhr);
    hw = -1;
    for (int w = 0; w < NWAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == tag_of(pc)) hw = w;
    if (hw >= 0) begin
      if (m_tgt[s][hw] == tgt) m_conf[s][hw] = (m_conf[s][hw] < CONF_TOP) ? m_conf[s][hw] + 1 : CONF_TOP;
      else if (m_conf[s][hw] == 0) m_tgt[s][hw] = tgt;
      else m_conf[s][hw] = m_conf[s][hw] - 1;
    end else begin
      aw = -1;
      for (int w = 0; w < NWAYS; w++)
        if (!m_valid[s][w] && aw < 0) aw = w;
      if (aw < 0) begin
        aw = m_vict[s];
        m_vict[s] = (m_vict[s] + 1) % NWAYS;
      end
      m_valid[s][aw] = 1'b1;
      m_tag[s][aw]   = tag_of(pc);
      m_tgt[s][aw]   = tgt;
      m_conf[s][aw]  = 0;
    end
  endtask

  task automatic step(input bit le, input logic [31:0] lpc, input logic [3:0] lbhr,
                      input bit ue, input logic [31:0] upc, input logic [3:0] ubhr,
                      input logic [31:0] ut, input bit fl);
    @(negedge clk);
    lookup_en = le; lookup_pc = lpc; lookup_bhr = lbhr;
    update_en = ue; update_pc = upc; update_bhr = ubhr; update_target = ut;
    flush = fl;
    if (le) begin
      e_valid = 1'b1;
      model_lookup(lpc, lbhr, e_hit, e_tgt, e_conf);
    end else begin
      e_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    if (fl) model_flush();
    else if (ue) model_update(upc, ubhr, ut);
    chk("pred_valid", 32'(pred_valid), 32'(e_valid));
    chk("pred_hit", 32'(pred_hit), 32'(e_hit));
    chk("pred_target", pred_target, e_tgt);
    chk("pred_conf", 32'(pred_conf), 32'(e_conf));
  endtask

  task automatic upd(input logic [31:0] pc, input logic [3:0] bhr, input logic [31:0] t);
    step(1'b0, 32'h0, 4'h0, 1'b1, pc, bhr, t, 1'b0);
  endtask

  task automatic look(input logic [31:0] pc, input logic [3:0] bhr);
    step(1'b1, pc, bhr, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; lookup_en = 1'b0; lookup_pc = 32'h0; lookup_bhr = 4'h0;
    update_en = 1'b0; update_pc = 32'h0; update_bhr = 4'h0; update_target = 32'h0; flush = 1'b0;
    e_valid = 1'b0; e_hit = 1'b0; e_tgt = 32'h0; e_conf = 2'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(pred_valid), 32'h0);
    chk("rst_hit", 32'(pred_hit), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // allocate then hit
    look(32'h0000_1234, 4'h5);
    upd(32'h0000_1234, 4'h5, 32'h8000_0000);
    look(32'h0000_1234, 4'h5);
    chk("alloc_hit", 32'(pred_hit), 32'h1);
    chk("alloc_target", pred_target, 32'h8000_0000);
    chk("alloc_conf", 32'(pred_conf), 32'h0);

    // confidence climbs and saturates
    for (int i = 0; i < 4; i++) upd(32'h0000_1234, 4'h5, 32'h8000_0000);
    look(32'h0000_1234, 4'h5);
    chk("conf_sat", 32'(pred_conf), 32'h3);

    // wrong target drains confidence before replacing
    for (int i = 0; i < 3; i++) begin
      upd(32'h0000_1234, 4'h5, 32'h9000_0000);
      look(32'h0000_1234, 4'h5);
      chk("hyst_target_kept", pred_target, 32'h8000_0000);
    end
    chk("hyst_conf_zero", 32'(pred_conf), 32'h0);
    upd(32'h0000_1234, 4'h5, 32'h9000_0000);
    look(32'h0000_1234, 4'h5);
    chk("hyst_replaced", pred_target, 32'h9000_0000);

    // aliasing pcs in one set; third allocation evicts way 0, fourth evicts way 1
    upd(32'h0000_0034, 4'h0, 32'h0000_1000);
    upd(32'h0000_0434, 4'h0, 32'h0000_2000);
    upd(32'h0000_0834, 4'h0, 32'h0000_3000);
    look(32'h0000_0034, 4'h0);
    chk("evict_miss", 32'(pred_hit), 32'h0);
    chk("evict_miss_tgt", pred_target, 32'h0);
    look(32'h0000_0434, 4'h0);
    chk("alias_keep", pred_target, 32'h0000_2000);
    upd(32'h0000_0C34, 4'h0, 32'h0000_4000);
    look(32'h0000_0434, 4'h0);
    chk("victim_adv_miss", 32'(pred_hit), 32'h0);
    look(32'h0000_0834, 4'h0);
    chk("victim_adv_keep", pred_target, 32'h0000_3000);

    // same-cycle lookup and allocating update to an empty set
    step(1'b1, 32'h0000_2227, 4'h3, 1'b1, 32'h0000_2227, 4'h3, 32'h0000_5000, 1'b0);
    chk("same_cycle_miss", 32'(pred_hit), 32'h0);
    look(32'h0000_2227, 4'h3);
    chk("same_cycle_next", pred_target, 32'h0000_5000);

    // flush drops the same-cycle update but the lookup sees old contents
    step(1'b1, 32'h0000_0834, 4'h0, 1'b1, 32'h0000_5555, 4'h1, 32'h0000_6000, 1'b1);
    chk("flush_cycle_hit", 32'(pred_hit), 32'h1);
    look(32'h0000_1234, 4'h5);
    chk("flush_miss_a", 32'(pred_hit), 32'h0);
    look(32'h0000_5555, 4'h1);
    chk("flush_drop_upd", 32'(pred_hit), 32'h0);

    // randomized traffic over a few aliasing sets
    for (int i = 0; i < 400; i++) begin
      logic [31:0] pc_l, pc_u, tg;
      pc_l = (32'($urandom_range(1, 4)) << 8) | (32'($urandom_range(1, 2)));
      pc_u = (32'($urandom_range(1, 4)) << 8) | (32'($urandom_range(1, 2)));
      tg   = 32'($urandom_range(1, 3)) << 12;
      step(1'($urandom_range(0, 9) < 7), pc_l, 4'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), pc_u, 4'($urandom_range(0, 1)), tg,
           1'($urandom_range(0, 49) == 0));
    end

    // async reset mid-run after a hitting lookup
    upd(32'h0000_1234, 4'h5, 32'h8000_0000);
    look(32'h0000_1234, 4'h5);
    chk("pre_reset_hit", 32'(pred_hit), 32'h1);
    @(negedge clk);
    lookup_en = 1'b0; update_en = 1'b0; flush = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid", 32'(pred_valid), 32'h0);
    chk("async_rst_hit", 32'(pred_hit), 32'h0);
    chk("async_rst_target", pred_target, 32'h0);
    chk("async_rst_conf", 32'(pred_conf), 32'h0);
    model_reset();
    e_hit = 1'b0; e_tgt = 32'h0; e_conf = 2'd0;
    @(negedge clk);
    reset = 1'b0;
    look(32'h0000_1234, 4'h5);
    chk("post_reset_miss", 32'(pred_hit), 32'h0);
    look(32'h0000_2227, 4'h3);
    chk("post_reset_miss_b", 32'(pred_hit), 32'h0);

    @(negedge clk);
    lookup_en = 1'b0; update_en = 1'b0; flush = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
